// File: rtl/cpu16_pkg.sv
// Shared encodings for the 16-bit multi-cycle CPU: opcodes, controller states,
// ALU operation codes, PC source selects and the decoded instruction class.
package cpu16_pkg;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_SLTI = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0011;
    localparam logic [3:0] OP_SW   = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_J    = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // is_imm_alu covers ADDI and SLTI; is_slti picks the compare within that class.
    typedef struct packed {
        logic is_r;
        logic is_imm_alu;
        logic is_slti;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_j;
        logic is_halt;
        logic is_illegal;
    } instr_class_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier feeding the main controller.
module control_decode
    import cpu16_pkg::*;
(
    input  logic [3:0]   opcode,
    output instr_class_t cls
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        cls = '0;
        case (opcode)
            OP_R:    cls.is_r       = 1'b1;
            OP_ADDI: cls.is_imm_alu = 1'b1;
            OP_SLTI: begin
                cls.is_imm_alu = 1'b1;
                cls.is_slti    = 1'b1;
            end
            OP_LW:   cls.is_lw      = 1'b1;
            OP_SW:   cls.is_sw      = 1'b1;
            OP_BEQ:  cls.is_beq     = 1'b1;
            OP_J:    cls.is_j       = 1'b1;
            OP_HALT: cls.is_halt    = 1'b1;
            default: cls.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath strobes, stalls on mem_ready and counts retired instructions.
module multicycle_control
    import cpu16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_b,
    output logic [2:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    instr_class_t     cls;

    // Register and immediate fields belong to the datapath, not the controller.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[11:0];

    control_decode u_decode (
        .opcode (instr[15:12]),
        .cls    (cls)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (cls.is_halt) begin
                    state_d = S_HALT;
                end else if (cls.is_j || cls.is_illegal) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls.is_lw || cls.is_sw) begin
                    state_d = S_MEM;
                end else if (cls.is_beq) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cls.is_lw) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    // Synchronous reset: rst_n is only looked at on the rising edge.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Strobes decode the current state and opcode; rst_n low forces everything quiet.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PC_INC;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        halted     = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: begin
                    if (cls.is_j) begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                    end
                end
                S_EXEC: begin
                    if (cls.is_r) begin
                        alu_op = ALU_FUNCT;
                    end else if (cls.is_imm_alu) begin
                        alu_src_b = 1'b1;
                        alu_op    = cls.is_slti ? ALU_SLT : ALU_ADD;
                    end else if (cls.is_lw || cls.is_sw) begin
                        alu_src_b = 1'b1;
                    end else if (cls.is_beq) begin
                        alu_op   = ALU_SUB;
                        pc_src   = PC_BRANCH;
                        pc_write = zero;
                    end
                end
                S_MEM: begin
                    mem_read  = cls.is_lw;
                    mem_write = cls.is_sw;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = cls.is_r;
                    mem_to_reg = cls.is_lw;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
